// File: rtl/rr_idx_arbiter.sv
// Registered round-robin arbiter with a binary-index grant and a valid/ready
// handshake. The search pointer (last_idx) advances whenever a winner is
// registered, so a flushed grant still counts as having taken its turn.
module rr_idx_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic [NUM_REQ-1:0]   request,
    output logic                 grant_valid,
    input  logic                 grant_ready,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    logic [IDX_WIDTH-1:0] last_idx;
    logic [IDX_WIDTH-1:0] winner;
    logic                 any_req;
    logic                 load;

    assign any_req = |request;
    assign load    = !grant_valid || grant_ready;

    // Round-robin search starting one past last_idx, wrapping at NUM_REQ
    // (not at 2^IDX_WIDTH) so last_idx itself is examined last.
    always_comb begin
        int unsigned start;
        int unsigned cand;
        logic        found;
        winner = '0;
        found  = 1'b0;
        cand   = 0;
        start  = (32'(last_idx) == NUM_REQ - 1) ? 0 : 32'(last_idx) + 1;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = start + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!found && request[cand[IDX_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_WIDTH-1:0];
            end
        end
    end

    // Grant register and pointer: flush drops the pending grant but keeps the
    // pointer advance; a stalled grant holds regardless of request changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last_idx    <= IDX_WIDTH'(NUM_REQ - 1);
        end else if (flush) begin
            grant_valid <= 1'b0;
        end else if (load) begin
            if (any_req) begin
                grant_valid <= 1'b1;
                grant_idx   <= winner;
                last_idx    <= winner;
            end else begin
                grant_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_idx_arbiter.sv
// Bench for rr_idx_arbiter: a cycle-level reference model for a 4-requestor
// and a 3-requestor instance, checked every cycle, plus directed sequences
// with hand-computed grant indices.
module tb_rr_idx_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       flush4 = 1'b0;
    logic [3:0] request4 = '0;
    logic       ready4 = 1'b0;
    logic       valid4;
    logic [1:0] idx4;

    logic       flush3 = 1'b0;
    logic [2:0] request3 = '0;
    logic       ready3 = 1'b0;
    logic       valid3;
    logic [1:0] idx3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_idx_arbiter #(.NUM_REQ(4)) dut4 (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush4),
        .request    (request4),
        .grant_valid(valid4),
        .grant_ready(ready4),
        .grant_idx  (idx4)
    );

    rr_idx_arbiter #(.NUM_REQ(3)) dut3 (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush3),
        .request    (request3),
        .grant_valid(valid3),
        .grant_ready(ready3),
        .grant_idx  (idx3)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Next requestor after 'last' in circular order among n requestors, or -1.
    function automatic int pick(input int req, input int last, input int n);
        for (int k = 1; k <= n; k++) begin
            int i;
            i = (last + k) % n;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    int m_v4, m_i4, m_l4;
    int m_v3, m_i3, m_l3;

    // Reference model, 4 requestors.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_v4 <= 0; m_i4 <= 0; m_l4 <= 3;
        end else if (flush4) begin
            m_v4 <= 0;
        end else if (m_v4 == 0 || ready4) begin
            if (pick(int'(request4), m_l4, 4) >= 0) begin
                m_v4 <= 1;
                m_i4 <= pick(int'(request4), m_l4, 4);
                m_l4 <= pick(int'(request4), m_l4, 4);
            end else begin
                m_v4 <= 0;
            end
        end
    end

    // Reference model, 3 requestors.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_v3 <= 0; m_i3 <= 0; m_l3 <= 2;
        end else if (flush3) begin
            m_v3 <= 0;
        end else if (m_v3 == 0 || ready3) begin
            if (pick(int'(request3), m_l3, 3) >= 0) begin
                m_v3 <= 1;
                m_i3 <= pick(int'(request3), m_l3, 3);
                m_l3 <= pick(int'(request3), m_l3, 3);
            end else begin
                m_v3 <= 0;
            end
        end
    end

    // Per-cycle comparison against the models.
    always @(negedge clk) begin
        chk("model_valid4", int'(valid4), m_v4);
        chk("model_idx4", int'(idx4), m_i4);
        chk("model_valid3", int'(valid3), m_v3);
        chk("model_idx3", int'(idx3), m_i3);
        chk("range_idx3", int'(idx3 <= 2'd2), 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        request4 = '0; ready4 = 1'b0; flush4 = 1'b0;
        request3 = '0; ready3 = 1'b0; flush3 = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        int exp_seq[6];

        // Reset state
        do_reset();
        chk("reset_valid", int'(valid4), 0);
        chk("reset_idx", int'(idx4), 0);

        // 1: all requesting, full throughput
        exp_seq = '{0, 1, 2, 3, 0, 1};
        request4 = 4'b1111; ready4 = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            tick();
            chk("t1_valid", int'(valid4), 1);
            chk("t1_idx", int'(idx4), exp_seq[k]);
        end

        // 2: sparse requests, then none
        do_reset();
        exp_seq = '{1, 3, 1, 3, 0, 0};
        request4 = 4'b1010; ready4 = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            chk("t2_idx", int'(idx4), exp_seq[k]);
        end
        request4 = 4'b0000;
        tick();
        chk("t2_idle_valid", int'(valid4), 0);
        chk("t2_idle_idx", int'(idx4), 3);

        // 3: stall holds the grant while requests change
        do_reset();
        request4 = 4'b0100; ready4 = 1'b1;
        tick();
        chk("t3_first_idx", int'(idx4), 2);
        ready4 = 1'b0; request4 = 4'b0001;
        for (int unsigned k = 0; k < 3; k++) begin
            tick();
            chk("t3_stall_valid", int'(valid4), 1);
            chk("t3_stall_idx", int'(idx4), 2);
        end
        ready4 = 1'b1;
        tick();
        chk("t3_after_idx", int'(idx4), 0);

        // 4: flush keeps the pointer advance
        do_reset();
        request4 = 4'b1111; ready4 = 1'b1;
        tick();
        tick();
        chk("t4_pre_idx", int'(idx4), 1);
        flush4 = 1'b1;
        tick();
        chk("t4_flush_valid", int'(valid4), 0);
        chk("t4_flush_idx", int'(idx4), 1);
        flush4 = 1'b0;
        tick();
        chk("t4_next_valid", int'(valid4), 1);
        chk("t4_next_idx", int'(idx4), 2);

        // 5: three requestors wrap at 3
        do_reset();
        exp_seq = '{0, 1, 2, 0, 1, 2};
        request3 = 3'b111; ready3 = 1'b1;
        for (int unsigned k = 0; k < 6; k++) begin
            tick();
            chk("t5_idx3", int'(idx3), exp_seq[k]);
        end

        // 6: asynchronous reset mid-stall, then a sole requestor repeats
        do_reset();
        request4 = 4'b1111; ready4 = 1'b1;
        tick();
        ready4 = 1'b0;
        tick();
        chk("t6_stall_valid", int'(valid4), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(valid4), 0);
        chk("t6_async_idx", int'(idx4), 0);
        request4 = 4'b1000; ready4 = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_first_idx", int'(idx4), 3);
        chk("t6_first_valid", int'(valid4), 1);
        tick();
        chk("t6_second_idx", int'(idx4), 3);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
